amber_wb_responder: RTL and testbench
=====================================

AMBER_WB_RESPONDER -- requirements
Module: amber_wb_responder

Interface
REQ-001 Parameters SHALL be, one per line:
- INST_DEPTH, 4: instruction-queue entries (power of 2).
- WAIT_STATES, 1: cycles inserted between request accept and ack (0..15).
- DATA_BASE, 32'h0000_1000: addresses >= DATA_BASE are the data region; below it is the instruction region.
- NOP_WORD, 32'hF0801003: filler instruction word.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, one per line:
- i_clk, in, 1: clock.
- i_rst, in, 1: synchronous active-high reset.
- i_wb_adr, in, 32: master address.
- i_wb_sel, in, 16: byte selects.
- i_wb_we, in, 1: write enable.
- i_wb_cyc, in, 1: bus cycle.
- i_wb_stb, in, 1: strobe.
- i_wb_dat, in, 128: master write data.
- o_wb_dat, out, 128: read data.
- o_wb_ack, out, 1: ack.
- o_wb_err, out, 1: error.
- i_inst_valid, in, 1: push instruction line.
- i_inst_data, in, 128: instruction line.
- o_inst_ready, out, 1: queue not full.
- i_ld_valid, in, 1: load-data word offered.
- i_ld_data, in, 32: load-data word.
- o_ld_ready, out, 1: load slot empty.
- o_st_valid, out, 1: store-captured pulse.
- o_st_adr, out, 32: store address.
- o_st_data, out, 32: store word.
- o_st_sel, out, 4: store byte lanes.
- o_xfer_count, out, 16: completed transfers, saturating.

Function
REQ-004 The FSM SHALL have the states IDLE, WAIT and RESP.
REQ-005 In IDLE, i_wb_cyc&i_wb_stb SHALL latch adr/sel/we/dat and go to WAIT; if WAIT_STATES==0, it goes directly to RESP.
REQ-006 In WAIT, a counter SHALL count WAIT_STATES cycles and then move to RESP.
REQ-007 If i_wb_cyc falls in WAIT, the block SHALL return to IDLE with no ack/err and no queue or slot change.
REQ-008 In RESP, exactly one of o_wb_ack or o_wb_err SHALL be high for exactly one cycle, and the next state is IDLE; back-to-back requests are therefore accepted no earlier than the cycle after RESP.
REQ-009 A read below DATA_BASE SHALL pop the instruction queue and return its line on o_wb_dat with ack. If the queue is empty, the block SHALL return {4{NOP_WORD}} with ack.
REQ-010 A read at or above DATA_BASE with the load slot full SHALL return i_ld_data (as latched) in lane adr[3:2], zero the other lanes, clear the slot, and ack. With the slot empty it SHALL assert err with o_wb_dat=0.
REQ-011 A write at or above DATA_BASE SHALL ack and pulse o_st_valid for one cycle in the RESP cycle. o_st_adr SHALL be the latched address, o_st_data the lane adr[3:2] of the write data, and o_st_sel the matching sel nibble.
REQ-012 A write below DATA_BASE, or a write with a zero sel nibble for lane adr[3:2], SHALL assert err and SHALL NOT pulse o_st_valid.
REQ-013 o_wb_dat SHALL be zero in every cycle other than a read ack.
REQ-014 The instruction queue SHALL accept a push when i_inst_valid&o_inst_ready. A simultaneous push and pop SHALL be legal when full; count is unchanged and the pointers wrap mod INST_DEPTH. A push while full SHALL be dropped.
REQ-015 The load slot SHALL load on i_ld_valid&o_ld_ready. A simultaneous clear and load SHALL result in the slot full with the new word.
REQ-016 o_xfer_count SHALL increment on each ack and stick at 16'hFFFF; err does not count.

Reset
REQ-017 When i_rst is high at a clock edge, the FSM SHALL go to IDLE, the queue and slot SHALL become empty, and all counters SHALL clear. The outputs SHALL be o_wb_ack=0, o_wb_err=0, o_wb_dat=0, o_st_valid=0, o_st_adr=0, o_st_data=0, o_st_sel=0, o_inst_ready=1, o_ld_ready=1, o_xfer_count=0.
REQ-018 A reset during WAIT or RESP SHALL suppress any pending ack/err.

Structure
REQ-019 Package amber_wb_pkg SHALL hold the state enum, the bus widths (32/128/16) and the NOP_WORD default.
REQ-020 The instruction queue SHALL be a sub-module, amber_wb_sfifo (push/pop/full/empty/count).

Verification
REQ-021 Push 128'hF0801003F0801003F0801003F0800003, then read adr 0: ack exactly 2 cycles after accept (WAIT_STATES=1) with that line; o_xfer_count=1.
REQ-022 Load slot 32'h5, then read adr 32'h1004: o_wb_dat=128'h0000_0000_0000_0000_0000_0005_0000_0000, ack; o_ld_ready returns to 1.
REQ-023 Write adr 32'h1008, sel 16'h0F00, lane2=32'h6: ack, o_st_valid pulse, o_st_data=6, o_st_sel=4'hF.
REQ-024 Read adr 0 with the queue empty returns {4{32'hF0801003}} with ack. Read 32'h1000 with the slot empty gives err, o_wb_dat=0, and the count is unchanged.
REQ-025 Fill the queue to 4, then push and pop in the same cycle: count stays 4 and data order is preserved across the wrap.
REQ-026 Drop i_wb_cyc in WAIT, or assert i_rst in WAIT: no ack/err, queue count unchanged (reset: queue empty); the next request is served normally.

Source files
------------

// File: rtl/amber_wb_pkg.sv
// Shared types and widths for the amber Wishbone responder slice.
// Holds the FSM state enum, bus widths and the filler instruction word.
package amber_wb_pkg;

  localparam int ADR_W  = 32;
  localparam int DAT_W  = 128;
  localparam int SEL_W  = 16;
  localparam int LANE_W = 32;

  localparam logic [31:0] NOP_WORD_DEF = 32'hF0801003;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } wb_state_e;

endpackage

// File: rtl/amber_wb_sfifo.sv
// Synchronous show-ahead FIFO holding instruction lines.
// A push while full is only taken when a pop happens in the same cycle.
module amber_wb_sfifo #(
  parameter int DEPTH = 4,
  parameter int W     = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/amber_wb_responder.sv
// Wishbone slave model for the amber core: serves instruction lines from a
// queue, load data from a one-word slot, and captures stores.
module amber_wb_responder
  import amber_wb_pkg::*;
#(
  parameter int          INST_DEPTH  = 4,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] DATA_BASE   = 32'h0000_1000,
  parameter logic [31:0] NOP_WORD    = NOP_WORD_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [ADR_W-1:0]   i_wb_adr,
  input  logic [SEL_W-1:0]   i_wb_sel,
  input  logic               i_wb_we,
  input  logic               i_wb_cyc,
  input  logic               i_wb_stb,
  input  logic [DAT_W-1:0]   i_wb_dat,
  output logic [DAT_W-1:0]   o_wb_dat,
  output logic               o_wb_ack,
  output logic               o_wb_err,
  input  logic               i_inst_valid,
  input  logic [DAT_W-1:0]   i_inst_data,
  output logic               o_inst_ready,
  input  logic               i_ld_valid,
  input  logic [LANE_W-1:0]  i_ld_data,
  output logic               o_ld_ready,
  output logic               o_st_valid,
  output logic [ADR_W-1:0]   o_st_adr,
  output logic [LANE_W-1:0]  o_st_data,
  output logic [3:0]         o_st_sel,
  output logic [15:0]        o_xfer_count
);

  localparam int         INST_AW   = $clog2(INST_DEPTH);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  wb_state_e          state_q, state_d;
  logic [3:0]         wait_cnt;
  logic [ADR_W-1:0]   adr_q;
  logic [SEL_W-1:0]   sel_q;
  logic               we_q;
  logic [DAT_W-1:0]   dat_q;
  logic               ld_full;
  logic [LANE_W-1:0]  ld_q;
  logic [15:0]        xfer_q;

  logic               accept;
  logic               inst_pop;
  logic               ld_clear;
  logic               ld_load;
  logic [DAT_W-1:0]   inst_rdata;
  logic               inst_full;
  logic               inst_empty;
  logic [INST_AW:0]   inst_count;
  logic [1:0]         lane;
  logic               is_data;
  logic [3:0]         sel_nib;
  logic [LANE_W-1:0]  wr_lane;
  logic               unused_ok;

  // Side channels use valid/ready: a word moves on a cycle where both are
  // high; a full queue or slot also takes a word when it drains that cycle.
  amber_wb_sfifo #(.DEPTH(INST_DEPTH), .W(DAT_W)) u_inst_q (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (i_inst_valid),
    .pop   (inst_pop),
    .wdata (i_inst_data),
    .rdata (inst_rdata),
    .full  (inst_full),
    .empty (inst_empty),
    .count (inst_count)
  );

  assign unused_ok    = ^inst_count;
  assign o_inst_ready = ~inst_full;
  assign o_ld_ready   = ~ld_full;
  assign ld_load      = i_ld_valid & (~ld_full | ld_clear);
  assign lane         = adr_q[3:2];
  assign is_data      = (adr_q >= DATA_BASE);
  assign sel_nib      = sel_q[{lane, 2'b00} +: 4];
  assign wr_lane      = dat_q[{lane, 5'b00000} +: LANE_W];
  assign o_st_adr     = adr_q;
  assign o_st_data    = wr_lane;
  assign o_st_sel     = sel_nib;
  assign o_xfer_count = xfer_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      wait_cnt <= '0;
      adr_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      dat_q    <= '0;
      ld_full  <= 1'b0;
      ld_q     <= '0;
      xfer_q   <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= (state_q == ST_WAIT) ? wait_cnt + 1'b1 : '0;
      if (accept) begin
        adr_q <= i_wb_adr;
        sel_q <= i_wb_sel;
        we_q  <= i_wb_we;
        dat_q <= i_wb_dat;
      end
      if (ld_load) begin
        ld_full <= 1'b1;
        ld_q    <= i_ld_data;
      end else if (ld_clear) begin
        ld_full <= 1'b0;
      end
      if (o_wb_ack && xfer_q != 16'hFFFF) xfer_q <= xfer_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    inst_pop   = 1'b0;
    ld_clear   = 1'b0;
    o_wb_ack   = 1'b0;
    o_wb_err   = 1'b0;
    o_wb_dat   = '0;
    o_st_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          accept  = 1'b1;
          state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!i_wb_cyc)                  state_d = ST_IDLE;
        else if (wait_cnt == WAIT_LAST) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        // A reset landing on the response cycle swallows the response.
        if (!i_rst) begin
          if (!we_q && !is_data) begin
            o_wb_ack = 1'b1;
            inst_pop = ~inst_empty;
            o_wb_dat = inst_empty ? {4{NOP_WORD}} : inst_rdata;
          end else if (!we_q) begin
            if (ld_full) begin
              o_wb_ack = 1'b1;
              ld_clear = 1'b1;
              for (int l = 0; l < 4; l++) begin
                if (2'(l) == lane) o_wb_dat[l*LANE_W +: LANE_W] = ld_q;
              end
            end else begin
              o_wb_err = 1'b1;
            end
          end else if (is_data && sel_nib != 4'h0) begin
            o_wb_ack   = 1'b1;
            o_st_valid = 1'b1;
          end else begin
            o_wb_err = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_amber_wb_responder.sv
// Directed bench for amber_wb_responder: bus responses are checked against
// a scoreboard queue fed by small models of the instruction queue and slot.
module tb_amber_wb_responder;

  localparam logic [127:0] NOP4 = {4{32'hF0801003}};

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [31:0]  i_wb_adr;
  logic [15:0]  i_wb_sel;
  logic         i_wb_we;
  logic         i_wb_cyc;
  logic         i_wb_stb;
  logic [127:0] i_wb_dat;
  logic [127:0] o_wb_dat;
  logic         o_wb_ack;
  logic         o_wb_err;
  logic         i_inst_valid;
  logic [127:0] i_inst_data;
  logic         o_inst_ready;
  logic         i_ld_valid;
  logic [31:0]  i_ld_data;
  logic         o_ld_ready;
  logic         o_st_valid;
  logic [31:0]  o_st_adr;
  logic [31:0]  o_st_data;
  logic [3:0]   o_st_sel;
  logic [15:0]  o_xfer_count;

  amber_wb_responder dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_wb_adr     (i_wb_adr),
    .i_wb_sel     (i_wb_sel),
    .i_wb_we      (i_wb_we),
    .i_wb_cyc     (i_wb_cyc),
    .i_wb_stb     (i_wb_stb),
    .i_wb_dat     (i_wb_dat),
    .o_wb_dat     (o_wb_dat),
    .o_wb_ack     (o_wb_ack),
    .o_wb_err     (o_wb_err),
    .i_inst_valid (i_inst_valid),
    .i_inst_data  (i_inst_data),
    .o_inst_ready (o_inst_ready),
    .i_ld_valid   (i_ld_valid),
    .i_ld_data    (i_ld_data),
    .o_ld_ready   (o_ld_ready),
    .o_st_valid   (o_st_valid),
    .o_st_adr     (o_st_adr),
    .o_st_data    (o_st_data),
    .o_st_sel     (o_st_sel),
    .o_xfer_count (o_xfer_count)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int            errors = 0;
  int            checks = 0;
  logic [129:0]  exp_q[$];     // {ack, err, dat}
  logic [127:0]  minst_q[$];   // model of the instruction queue
  logic          mld_full = 1'b0;
  logic [31:0]   mld_data = '0;
  logic [15:0]   exp_xfer = '0;
  logic          mon_en = 1'b0;

  logic          side_push = 1'b0;
  logic [127:0]  side_push_data = '0;
  logic          side_ld = 1'b0;
  logic [31:0]   side_ld_data = '0;
  logic          got_st_valid;
  logic [31:0]   got_st_adr;
  logic [31:0]   got_st_data;
  logic [3:0]    got_st_sel;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Read data must be zero outside read acks; a store pulse needs an ack.
  always @(negedge i_clk) begin
    if (mon_en && !o_wb_ack) chk("dat_idle_zero", o_wb_dat, 128'h0);
    if (mon_en && o_st_valid) chk("st_valid_with_ack", {127'h0, o_wb_ack}, 128'h1);
  end

  // ---------------- driver tasks ----------------
  task automatic push_inst(input logic [127:0] d);
    @(negedge i_clk);
    if (minst_q.size() < 4) minst_q.push_back(d);
    i_inst_valid = 1'b1;
    i_inst_data  = d;
    @(negedge i_clk);
    i_inst_valid = 1'b0;
  endtask

  task automatic load_slot(input logic [31:0] d);
    @(negedge i_clk);
    if (!mld_full) begin
      mld_full = 1'b1;
      mld_data = d;
    end
    i_ld_valid = 1'b1;
    i_ld_data  = d;
    @(negedge i_clk);
    i_ld_valid = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] adr, input logic [15:0] sel, input logic we,
                        input logic [127:0] wdat, input logic exp_ack, input logic [127:0] exp_dat);
    int n;
    logic done;
    logic [129:0] e;
    logic [127:0] g_dat;
    logic g_ack, g_err;
    exp_q.push_back({exp_ack, ~exp_ack, exp_dat});
    if (exp_ack) exp_xfer++;
    @(negedge i_clk);
    i_wb_adr = adr; i_wb_sel = sel; i_wb_we = we; i_wb_dat = wdat;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    n = 0; done = 1'b0;
    g_dat = '0; g_ack = 1'b0; g_err = 1'b0;
    while (!done && n < 40) begin
      @(posedge i_clk);
      @(negedge i_clk);
      n++;
      if (n == 1) i_wb_stb = 1'b0;
      if (o_wb_ack || o_wb_err) begin
        done = 1'b1;
        g_dat = o_wb_dat; g_ack = o_wb_ack; g_err = o_wb_err;
        got_st_valid = o_st_valid; got_st_adr = o_st_adr;
        got_st_data = o_st_data; got_st_sel = o_st_sel;
        if (side_push) begin i_inst_valid = 1'b1; i_inst_data = side_push_data; end
        if (side_ld)   begin i_ld_valid = 1'b1;   i_ld_data = side_ld_data;     end
      end
    end
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    e = exp_q.pop_front();
    if (!done) begin
      chk("resp_timeout", 128'h0, 128'h1);
    end else begin
      chk("ack", {127'h0, g_ack}, {127'h0, e[129]});
      chk("err", {127'h0, g_err}, {127'h0, e[128]});
      chk("rdata", g_dat, e[127:0]);
      chk("latency", 128'(n), 128'd2);
    end
    @(negedge i_clk);
    i_inst_valid = 1'b0; i_ld_valid = 1'b0;
    side_push = 1'b0; side_ld = 1'b0;
    chk("xfer_count", {112'h0, o_xfer_count}, {112'h0, exp_xfer});
  endtask

  task automatic read_inst();
    logic [127:0] exp;
    exp = (minst_q.size() == 0) ? NOP4 : minst_q.pop_front();
    if (side_push) minst_q.push_back(side_push_data);
    do_req(32'h0, 16'hFFFF, 1'b0, '0, 1'b1, exp);
  endtask

  task automatic read_data(input logic [31:0] adr);
    logic [127:0] exp;
    logic ok;
    exp = '0;
    ok = mld_full;
    if (ok) exp[{adr[3:2], 5'b00000} +: 32] = mld_data;
    mld_full = 1'b0;
    if (side_ld) begin mld_full = 1'b1; mld_data = side_ld_data; end
    do_req(adr, 16'hFFFF, 1'b0, '0, ok, exp);
  endtask

  // mode 0 drops cyc in WAIT, mode 1 pulses reset in WAIT
  task automatic abort_req(input logic [31:0] adr, input int mode);
    int seen;
    @(negedge i_clk);
    i_wb_adr = adr; i_wb_sel = 16'hFFFF; i_wb_we = 1'b0; i_wb_dat = '0;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_wb_stb = 1'b0;
    if (mode == 0) begin
      i_wb_cyc = 1'b0;
    end else begin
      i_rst = 1'b1;
      minst_q.delete(); mld_full = 1'b0; exp_xfer = '0;
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0; i_wb_cyc = 1'b0;
      if (o_wb_ack || o_wb_err) seen++;
    end
    chk(mode == 0 ? "abort_cyc_noresp" : "abort_rst_noresp", 128'(seen), 128'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    i_rst = 1'b1; i_wb_adr = '0; i_wb_sel = '0; i_wb_we = 1'b0;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_dat = '0;
    i_inst_valid = 1'b0; i_inst_data = '0; i_ld_valid = 1'b0; i_ld_data = '0;
    got_st_valid = 1'b0; got_st_adr = '0; got_st_data = '0; got_st_sel = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ack", {127'h0, o_wb_ack}, 128'h0);
    chk("rst_err", {127'h0, o_wb_err}, 128'h0);
    chk("rst_dat", o_wb_dat, 128'h0);
    chk("rst_st", {o_st_valid, o_st_adr, o_st_data, o_st_sel}, 128'h0);
    chk("rst_readies", {126'h0, o_inst_ready, o_ld_ready}, 128'h3);
    chk("rst_xfer", {112'h0, o_xfer_count}, 128'h0);
    i_rst = 1'b0;
    mon_en = 1'b1;

    // instruction line with the 2-cycle response latency
    push_inst(128'hF0801003F0801003F0801003F0800003);
    read_inst();

    // load slot returned in lane adr[3:2]
    load_slot(32'h5);
    chk("ld_ready_full", {127'h0, o_ld_ready}, 128'h0);
    read_data(32'h1004);
    chk("ld_ready_after", {127'h0, o_ld_ready}, 128'h1);

    // captured store
    do_req(32'h1008, 16'h0F00, 1'b1, 128'h0000_0000_0000_0006_0000_0000_0000_0000, 1'b1, '0);
    chk("st_valid", {127'h0, got_st_valid}, 128'h1);
    chk("st_adr", {96'h0, got_st_adr}, 128'h1008);
    chk("st_data", {96'h0, got_st_data}, 128'h6);
    chk("st_sel", {124'h0, got_st_sel}, 128'hF);

    // empty queue, empty slot, bad writes
    read_inst();
    read_data(32'h1000);
    do_req(32'h10, 16'hFFFF, 1'b1, {4{32'hA5A5_0001}}, 1'b0, '0);
    chk("st_valid_low_region", {127'h0, got_st_valid}, 128'h0);
    do_req(32'h1004, 16'hFF0F, 1'b1, {4{32'hA5A5_0002}}, 1'b0, '0);
    chk("st_valid_zero_sel", {127'h0, got_st_valid}, 128'h0);

    // fill, drop a push while full, then push and pop together across the wrap
    for (int i = 0; i < 4; i++) begin
      chk("inst_ready_fill", {127'h0, o_inst_ready}, 128'h1);
      push_inst({96'h0, 32'($urandom_range(1, 32'h7FFF_FFFF))} | (128'(i) << 120));
    end
    chk("inst_ready_full", {127'h0, o_inst_ready}, 128'h0);
    push_inst(128'hDEAD);
    side_push = 1'b1;
    side_push_data = 128'hCAFE_0004;
    read_inst();
    chk("inst_ready_wrap", {127'h0, o_inst_ready}, 128'h0);
    for (int i = 0; i < 5; i++) read_inst();

    // cyc dropped in WAIT leaves the queue alone
    push_inst(128'hABCD_0001);
    abort_req(32'h0, 0);
    read_inst();

    // reset in WAIT empties queue and slot
    push_inst(128'hABCD_0002);
    load_slot(32'h11);
    abort_req(32'h0, 1);
    chk("ld_ready_rst", {127'h0, o_ld_ready}, 128'h1);
    read_inst();

    // slot cleared and reloaded in the same cycle
    load_slot(32'h7);
    side_ld = 1'b1;
    side_ld_data = 32'h9;
    read_data(32'h1000);
    chk("ld_ready_reload", {127'h0, o_ld_ready}, 128'h0);
    read_data(32'h100C);

    repeat (2) @(negedge i_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
